// File: rtl/deci_to_gray_if.sv
// Conversion request/result bundle for deci_to_gray.
// The producer drives the request; the converter returns a registered result.
interface deci_to_gray_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] G;
  logic             out_valid;
  logic             parity;

  modport master (
    output in_valid,
    output mode,
    output B,
    input  G,
    input  out_valid,
    input  parity
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  B,
    output G,
    output out_valid,
    output parity
  );
endinterface

// File: rtl/deci_to_gray.sv
// Registered binary<->Gray converter: one conversion per clock, 1-cycle latency,
// with a valid flag and the XOR parity of the accepted input word.
module deci_to_gray #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  deci_to_gray_if.slave bus
);

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin);
    bin_to_gray = bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB downward.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] gray);
    logic [WIDTH-1:0] res;
    res[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      res[i] = res[i+1] ^ gray[i];
    end
    gray_to_bin = res;
  endfunction

  function automatic logic xor_parity(input logic [WIDTH-1:0] word);
    xor_parity = ^word;
  endfunction

  logic [WIDTH-1:0] result_s;
  logic             parity_s;
  logic [WIDTH-1:0] g_r;
  logic             out_valid_r;
  logic             parity_r;

  // Select the conversion direction for the current sample.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    parity_s = xor_parity(bus.B);
    case (bus.mode)
      1'b0:    result_s = bin_to_gray(bus.B);
      1'b1:    result_s = gray_to_bin(bus.B);
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Output registers; idle cycles hold G and parity so unsampled inputs never leak through.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      parity_r    <= 1'b0;
    end else if (bus.in_valid) begin
      g_r         <= result_s;
      out_valid_r <= 1'b1;
      parity_r    <= parity_s;
    end else begin
      g_r         <= g_r;
      out_valid_r <= 1'b0;
      parity_r    <= parity_r;
    end
  end

  assign bus.G         = g_r;
  assign bus.out_valid = out_valid_r;
  assign bus.parity    = parity_r;

endmodule

// File: tb/tb_deci_to_gray.sv
// Directed, table-driven bench for deci_to_gray (WIDTH=4).
module tb_deci_to_gray;

  localparam int W = 4;

  typedef struct {
    logic         mode;
    logic [W-1:0] b;
    logic [W-1:0] g;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  deci_to_gray_if #(.WIDTH(W)) bus ();

  deci_to_gray #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic m, input logic [W-1:0] b);
    bus.in_valid = v;
    bus.mode     = m;
    bus.B        = b;
    @(posedge clk);
    #1;
  endtask

  vec_t         vt [24];
  logic [W-1:0] enc_g [16];
  logic [W-1:0] prev_g;
  logic         exp_par;

  initial begin
    errors = 0;
    checks = 0;
    enc_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 16; i++) begin
      vt[i].mode = 1'b0;
      vt[i].b    = 4'(i);
      vt[i].g    = enc_g[i];
    end
    vt[16] = '{1'b0, 4'b0000, 4'b0000};
    vt[17] = '{1'b0, 4'b0111, 4'b0100};
    vt[18] = '{1'b1, 4'b0100, 4'b0111};
    vt[19] = '{1'b1, 4'b0010, 4'b0011};
    vt[20] = '{1'b1, 4'b1000, 4'b1111};
    vt[21] = '{1'b1, 4'b1111, 4'b1010};
    vt[22] = '{1'b1, 4'b0000, 4'b0000};
    vt[23] = '{1'b1, 4'b0110, 4'b0100};

    // Reset dominates a valid request.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 4'b1111);
      check("reset_g", 32'(bus.G), 32'h0);
      check("reset_valid", 32'(bus.out_valid), 32'h0);
      check("reset_parity", 32'(bus.parity), 32'h0);
    end
    rst = 1'b0;

    // Single encode, then an idle cycle with X on B.
    step(1'b1, 1'b0, 4'b0011);
    check("enc_basic_g", 32'(bus.G), 32'h2);
    check("enc_basic_valid", 32'(bus.out_valid), 32'h1);
    check("enc_basic_parity", 32'(bus.parity), 32'h0);
    step(1'b0, 1'b0, 4'bxxxx);
    check("idle_hold_g", 32'(bus.G), 32'h2);
    check("idle_valid", 32'(bus.out_valid), 32'h0);
    check("idle_hold_parity", 32'(bus.parity), 32'h0);

    // Back-to-back stream: exhaustive encode, wrap, mode toggles, decodes.
    prev_g = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, vt[i].mode, vt[i].b);
      exp_par = ^vt[i].b;
      check("vec_g", 32'(bus.G), 32'(vt[i].g));
      check("vec_valid", 32'(bus.out_valid), 32'h1);
      check("vec_parity", 32'(bus.parity), 32'(exp_par));
      if (i > 0 && vt[i].mode == 1'b0 && vt[i-1].mode == 1'b0 && vt[i].b == vt[i-1].b + 4'd1)
        check("gray_adjacent", 32'($countones(bus.G ^ prev_g)), 32'h1);
      prev_g = bus.G;
    end

    // Mid-stream reset with in_valid held high.
    step(1'b1, 1'b0, 4'b0101);
    check("pre_rst_g", 32'(bus.G), 32'h7);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'b1001);
    check("midrst_g", 32'(bus.G), 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_parity", 32'(bus.parity), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 4'b0110);
    check("postrst_g", 32'(bus.G), 32'h5);
    check("postrst_valid", 32'(bus.out_valid), 32'h1);
    check("postrst_parity", 32'(bus.parity), 32'h0);
    step(1'b1, 1'b1, 4'b1101);
    check("postrst_dec_g", 32'(bus.G), 32'h9);
    check("postrst_dec_parity", 32'(bus.parity), 32'h1);
    step(1'b0, 1'b1, 4'bxxxx);
    check("final_idle_g", 32'(bus.G), 32'h9);
    check("final_idle_valid", 32'(bus.out_valid), 32'h0);
    check("final_idle_parity", 32'(bus.parity), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
